// File: rtl/wifi_tx_pkg.sv
// Shared constants and types for the 802.11a/g transmit chain.
// Holds the QPSK symbol geometry, the read FSM encoding and the output pair record.
package wifi_tx_pkg;

  localparam int WIFI_N_CBPS_QPSK = 96;
  localparam int WIFI_N_BPSC_QPSK = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic       valid;
    logic       sym_start;
    logic [1:0] data;
  } pair_out_t;

endpackage

// File: rtl/wifi_tx_intlv_perm.sv
// First interleaver permutation k -> j = (N_CBPS/16)*(k mod 16) + floor(k/16).
// The second permutation is identity for s=1; higher-order builds would add it here.
module wifi_tx_intlv_perm
  import wifi_tx_pkg::*;
#(
  parameter int N_CBPS = WIFI_N_CBPS_QPSK,
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0] k,
  input  logic              bypass,
  output logic [ADDR_W-1:0] j
);

  localparam int COLS = N_CBPS / 16;

  always_comb begin
    j = k;
    if (!bypass) j = ADDR_W'(COLS * int'(k[3:0]) + int'(k[ADDR_W-1:4]));
  end

endmodule

// File: rtl/wifi_tx_interleaver_qpsk.sv
// QPSK block interleaver: ping-pong banks, one coded bit in per cycle, one permuted pair out per cycle.
// Optional per-symbol bypass port under WIFI_TX_INTLV_BYPASS_EN.
module wifi_tx_interleaver_qpsk
  import wifi_tx_pkg::*;
#(
  parameter int N_CBPS = WIFI_N_CBPS_QPSK,
  parameter int ADDR_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       data_in,
  output logic       valid_out,
  output logic [1:0] data_out,
  output logic       sym_start_out
`ifdef WIFI_TX_INTLV_BYPASS_EN
  ,
  input  logic       bypass
`endif
);

  localparam int NPAIR = N_CBPS / WIFI_N_BPSC_QPSK;
  localparam int RD_W  = ADDR_W - 1;

  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              wr_last;
  logic              wr_wrap;
  logic              byp_eff;

  logic [N_CBPS-1:0] bank [2];

  rd_state_t         state_q, state_n;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_n;
  logic              rd_bank_q, rd_bank_n;
  logic              rd_last;
  pair_out_t         out_q, out_n;

  assign wr_last = (wr_cnt == ADDR_W'(N_CBPS - 1));
  assign wr_wrap = valid_in && wr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (valid_in) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

`ifdef WIFI_TX_INTLV_BYPASS_EN
  // Bypass is captured with bit 0 and held for the rest of the symbol.
  logic byp_sym;
  always_ff @(posedge clk) begin
    if (reset)                          byp_sym <= 1'b0;
    else if (valid_in && wr_cnt == '0)  byp_sym <= bypass;
  end
  assign byp_eff = (wr_cnt == '0) ? bypass : byp_sym;
`else
  assign byp_eff = 1'b0;
`endif

  wifi_tx_intlv_perm #(
    .N_CBPS (N_CBPS),
    .ADDR_W (ADDR_W)
  ) u_perm (
    .k      (wr_cnt),
    .bypass (byp_eff),
    .j      (wr_addr)
  );

  // Bank contents need no reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (valid_in) bank[wr_bank][wr_addr] <= data_in;
  end

  assign rd_last = (rd_cnt_q == RD_W'(NPAIR - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      rd_cnt_q  <= rd_cnt_n;
      rd_bank_q <= rd_bank_n;
    end
  end

  // Output regs load the pair addressed by the next-state counter, so pair 0 appears
  // the cycle after the edge that writes the last bit. Pair 0 never holds bit N_CBPS-1.
  always_comb begin
    state_n   = state_q;
    rd_cnt_n  = rd_cnt_q;
    rd_bank_n = rd_bank_q;
    out_n     = '0;
    case (state_q)
      ST_IDLE: ;
      ST_READ: begin
        if (rd_last) state_n  = ST_IDLE;
        else         rd_cnt_n = rd_cnt_q + 1'b1;
      end
    endcase
    if (wr_wrap) begin
      state_n   = ST_READ;
      rd_cnt_n  = '0;
      rd_bank_n = wr_bank;
    end
    if (state_n == ST_READ) begin
      out_n.valid     = 1'b1;
      out_n.sym_start = (rd_cnt_n == '0);
      out_n.data      = {bank[rd_bank_n][{rd_cnt_n, 1'b0}], bank[rd_bank_n][{rd_cnt_n, 1'b1}]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_n;
  end

  assign valid_out     = out_q.valid;
  assign sym_start_out = out_q.sym_start;
  assign data_out      = out_q.data;

  // A new symbol may only complete while idle or on the final pair of the current read.
  a_no_overrun: assert property (@(posedge clk) disable iff (reset)
    !(wr_wrap && state_q == ST_READ && !rd_last));

endmodule

// File: tb/tb_wifi_tx_interleaver_qpsk.sv
// Self-checking bench for wifi_tx_interleaver_qpsk: one-hot vector table, random
// back-to-back and gappy symbols against a permutation model, mid-stream reset, bypass build.
module tb_wifi_tx_interleaver_qpsk;

  localparam int  N    = 96;
  localparam int  NP   = 48;
  localparam time TCLK = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic       data_in;
  logic       valid_out;
  logic [1:0] data_out;
  logic       sym_start_out;
`ifdef WIFI_TX_INTLV_BYPASS_EN
  logic       bypass;
`endif

  always #5 clk = ~clk;

  wifi_tx_interleaver_qpsk dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .sym_start_out (sym_start_out)
`ifdef WIFI_TX_INTLV_BYPASS_EN
    ,
    .bypass        (bypass)
`endif
  );

  typedef struct {
    time        t;
    logic       st;
    logic [1:0] d;
  } cap_t;

  typedef struct {
    string      name;
    int         hot_k;
    int         pair;
    logic [1:0] exp_pair;
  } vec_t;

  cap_t cap_q[$];
  time  t95_q[$];
  int   idle_viol = 0;
  bit   mon_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out === 1'b1) cap_q.push_back('{$time, sym_start_out, data_out});
      else if (data_out !== 2'b00 || sym_start_out !== 1'b0) idle_viol++;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output stream position s (pair s/2, even s on data_out[1]) carries input bit k where s = j(k).
  function automatic logic [95:0] model(input logic [95:0] bits, input bit byp);
    logic [95:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s[byp ? k : (N / 16) * (k % 16) + k / 16] = bits[k];
    return s;
  endfunction

  task automatic send(input logic [95:0] bits, input int nbits, input bit gappy, input bit byp);
    for (int k = 0; k < nbits; k++) begin
      if (gappy) begin
        while ($urandom_range(0, 2) != 0) begin
          @(negedge clk);
          valid_in = 1'b0;
          data_in  = 1'($urandom);
`ifdef WIFI_TX_INTLV_BYPASS_EN
          bypass   = 1'($urandom);
`endif
        end
      end
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = bits[k];
`ifdef WIFI_TX_INTLV_BYPASS_EN
      bypass   = (k == 0) ? byp : 1'($urandom);
`else
      if (byp) $display("note: bypass requested in a build without the port");
`endif
      if (k == N - 1) t95_q.push_back($time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = 1'b0;
    end
  endtask

  task automatic check_sym(input string name, input logic [95:0] exp);
    int          waited;
    logic [95:0] got;
    time         t0, tb95;
    bit          contig, st_ok;
    cap_t        c;
    waited = 0;
    got    = '0;
    t0     = 0;
    contig = 1'b1;
    st_ok  = 1'b1;
    while (cap_q.size() < NP && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    tb95 = (t95_q.size() != 0) ? t95_q.pop_front() : 0;
    if (cap_q.size() < NP) begin
      chk({name, " pair count (timeout)"}, 96'(cap_q.size()), 96'(NP));
      cap_q.delete();
      return;
    end
    for (int m = 0; m < NP; m++) begin
      c = cap_q.pop_front();
      if (m == 0) t0 = c.t;
      else if (c.t != t0 + m * TCLK) contig = 1'b0;
      if (c.st !== (m == 0)) st_ok = 1'b0;
      got[2*m]   = c.d[1];
      got[2*m+1] = c.d[0];
    end
    chk({name, " data"}, got, exp);
    chk({name, " latency"}, 96'(t0 - tb95), 96'(TCLK));
    chk({name, " contiguous/sym_start"}, 96'({contig, st_ok}), 96'(2'b11));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[4];
    logic [95:0] one, bits, exp;
    logic [95:0] r[3];

    tbl[0] = '{"onehot_k1",  1,  3,  2'b10};
    tbl[1] = '{"onehot_k16", 16, 0,  2'b01};
    tbl[2] = '{"onehot_k95", 95, 47, 2'b01};
    tbl[3] = '{"onehot_k0",  0,  0,  2'b10};

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
`ifdef WIFI_TX_INTLV_BYPASS_EN
    bypass   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset valid_out", 96'(valid_out), 96'(0));
    chk("reset data_out", 96'(data_out), 96'(0));
    chk("reset sym_start_out", 96'(sym_start_out), 96'(0));
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    one = 96'd1;
    foreach (tbl[i]) begin
      bits = one << tbl[i].hot_k;
      exp  = '0;
      exp[2*tbl[i].pair]   = tbl[i].exp_pair[1];
      exp[2*tbl[i].pair+1] = tbl[i].exp_pair[0];
      send(bits, N, 1'b0, 1'b0);
      idle(60);
      check_sym(tbl[i].name, exp);
    end

    foreach (r[i]) r[i] = {$urandom, $urandom, $urandom};
    foreach (r[i]) send(r[i], N, 1'b0, 1'b0);
    idle(60);
    foreach (r[i]) check_sym($sformatf("b2b_sym%0d", i), model(r[i], 1'b0));

    r[0] = {$urandom, $urandom, $urandom};
    r[1] = {$urandom, $urandom, $urandom};
    send(r[0], N, 1'b1, 1'b0);
    send(r[1], N, 1'b1, 1'b0);
    idle(60);
    check_sym("gappy_sym0", model(r[0], 1'b0));
    check_sym("gappy_sym1", model(r[1], 1'b0));

    // Reset lands while one symbol is being read out and the next is partially written.
    r[0] = {$urandom, $urandom, $urandom};
    r[1] = {$urandom, $urandom, $urandom};
    send(r[0], N, 1'b0, 1'b0);
    send(r[1], 10, 1'b0, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset valid_out", 96'(valid_out), 96'(0));
    chk("midreset data_out", 96'(data_out), 96'(0));
    chk("midreset sym_start_out", 96'(sym_start_out), 96'(0));
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    t95_q.delete();
    idle(2);
    r[2] = {$urandom, $urandom, $urandom};
    send(r[2], N, 1'b0, 1'b0);
    idle(60);
    check_sym("post_reset", model(r[2], 1'b0));

`ifdef WIFI_TX_INTLV_BYPASS_EN
    for (int i = 0; i < 12; i++) bits[8*i +: 8] = 8'(i);
    r[0] = {$urandom, $urandom, $urandom};
    send(bits, N, 1'b0, 1'b1);
    send(r[0], N, 1'b0, 1'b0);
    idle(60);
    check_sym("bypass_ramp", bits);
    check_sym("bypass_off_toggled", model(r[0], 1'b0));
`endif

    idle(10);
    chk("outputs zero outside read", 96'(idle_viol), 96'(0));
    chk("no stray pairs", 96'(cap_q.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
